// File: rtl/except_pkg.sv
// except_pkg: shared constants for exception commit and CP0.
// Holds the excepttype bit positions, ExcCode values, excepttype_out codes,
// CP0 register addresses and the mtc0-writable bit masks.
package except_pkg;
    localparam int EXC_SYSCALL_BIT = 8;
    localparam int EXC_RI_BIT      = 9;
    localparam int EXC_OV_BIT      = 10;
    localparam int EXC_TRAP_BIT    = 11;
    localparam int EXC_ERET_BIT    = 12;

    localparam logic [4:0] CODE_INT  = 5'h00;
    localparam logic [4:0] CODE_SYS  = 5'h08;
    localparam logic [4:0] CODE_RI   = 5'h0a;
    localparam logic [4:0] CODE_OV   = 5'h0c;
    localparam logic [4:0] CODE_TRAP = 5'h0d;

    localparam logic [31:0] ET_NONE = 32'h0;
    localparam logic [31:0] ET_INT  = 32'h1;
    localparam logic [31:0] ET_SYS  = 32'h8;
    localparam logic [31:0] ET_RI   = 32'ha;
    localparam logic [31:0] ET_OV   = 32'hc;
    localparam logic [31:0] ET_TRAP = 32'hd;
    localparam logic [31:0] ET_ERET = 32'he;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // Cause.ExcCode for a committed excepttype_out code.
    function automatic logic [4:0] exc_code(input logic [31:0] et);
        return et == ET_SYS  ? CODE_SYS  :
               et == ET_RI   ? CODE_RI   :
               et == ET_OV   ? CODE_OV   :
               et == ET_TRAP ? CODE_TRAP : CODE_INT;
    endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: CP0 Count/Compare pair and the timer interrupt flag.
// Ports: clk, rst (async, active-high); we/waddr/wdata = committed mtc0
// (already suppressed by flush); count, compare, timer_int = state.
module cp0_timer
    import except_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);
    logic wr_count, wr_cmp;

    assign wr_count = we && waddr == CP0_COUNT;
    assign wr_cmp   = we && waddr == CP0_COMPARE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 32'h0;
            compare   <= 32'h0;
            timer_int <= 1'b0;
        end else begin
            count <= wr_count ? wdata : count + 32'd1;
            if (wr_cmp)
                compare <= wdata;
            // A write to Compare acknowledges the timer even on a match cycle.
            timer_int <= wr_cmp ? 1'b0 :
                         (count == compare && compare != 32'h0) ? 1'b1 : timer_int;
        end
    end
endmodule

// File: rtl/except_commit.sv
// except_commit: MEM-stage exception prioritisation and CP0 register file.
// Ports: clk, rst (async, active-high); mem_valid/mem_excepttype/mem_pc/
// mem_in_delayslot = instruction in MEM; int_i = hardware interrupts;
// cp0_we/cp0_waddr/cp0_wdata = mtc0 commit; cp0_raddr/cp0_rdata = mfc0;
// excepttype_out/flush/new_pc = redirect; timer_int = Count/Compare match.
module except_commit
    import except_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_excepttype,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delayslot,
    input  logic [5:0]  int_i,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic [31:0] excepttype_out,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        timer_int
);
    logic [31:0] count, compare, epc, epc_fwd, status_r, cause_r, reg_val, wmask;
    logic [7:0]  im, ip;
    logic [4:0]  exccode;
    logic        exl, ie, bd, int_pend, eret, take, wr;
    logic        unused;

    assign unused = ^{mem_excepttype[31:13], mem_excepttype[7:0]};

    assign int_pend = mem_valid && ie && !exl && |(ip & im);

    always_comb begin
        excepttype_out = !mem_valid                        ? ET_NONE :
                         int_pend                          ? ET_INT  :
                         mem_excepttype[EXC_SYSCALL_BIT]   ? ET_SYS  :
                         mem_excepttype[EXC_RI_BIT]        ? ET_RI   :
                         mem_excepttype[EXC_TRAP_BIT]      ? ET_TRAP :
                         mem_excepttype[EXC_OV_BIT]        ? ET_OV   :
                         mem_excepttype[EXC_ERET_BIT]      ? ET_ERET : ET_NONE;
    end

    assign flush   = excepttype_out != ET_NONE;
    assign eret    = excepttype_out == ET_ERET;
    assign take    = flush && !eret;
    assign wr      = cp0_we && !flush;
    // eret returns to an EPC written by an mtc0 in the same cycle.
    assign epc_fwd = (cp0_we && cp0_waddr == CP0_EPC) ? cp0_wdata : epc;
    assign new_pc  = !flush ? 32'h0 : eret ? epc_fwd : EXC_VECTOR;

    cp0_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .we        (wr),
        .waddr     (cp0_waddr),
        .wdata     (cp0_wdata),
        .count     (count),
        .compare   (compare),
        .timer_int (timer_int)
    );

    assign status_r = {16'h0, im, 6'h0, exl, ie};
    assign cause_r  = {bd, 15'h0, ip, 1'b0, exccode, 2'b0};

    always_comb begin
        reg_val = cp0_raddr == CP0_COUNT   ? count    :
                  cp0_raddr == CP0_COMPARE ? compare  :
                  cp0_raddr == CP0_STATUS  ? status_r :
                  cp0_raddr == CP0_CAUSE   ? cause_r  :
                  cp0_raddr == CP0_EPC     ? epc      : 32'h0;
        wmask   = (cp0_raddr == CP0_COUNT || cp0_raddr == CP0_COMPARE ||
                   cp0_raddr == CP0_EPC)   ? 32'hffff_ffff :
                  cp0_raddr == CP0_STATUS  ? STATUS_WMASK  :
                  cp0_raddr == CP0_CAUSE   ? CAUSE_WMASK   : 32'h0;
        cp0_rdata = (cp0_we && cp0_waddr == cp0_raddr) ? (cp0_wdata & wmask) : reg_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im      <= 8'h0;
            exl     <= 1'b0;
            ie      <= 1'b0;
            bd      <= 1'b0;
            ip      <= 8'h0;
            exccode <= 5'h0;
            epc     <= 32'h0;
        end else begin
            ip[7:2] <= {timer_int | int_i[5], int_i[4:0]};
            if (wr && cp0_waddr == CP0_CAUSE)
                ip[1:0] <= cp0_wdata[9:8];
            if (take) begin
                exl     <= 1'b1;
                exccode <= exc_code(excepttype_out);
                // A nested exception keeps the original return point.
                if (!exl) begin
                    epc <= mem_in_delayslot ? mem_pc - 32'd4 : mem_pc;
                    bd  <= mem_in_delayslot;
                end
            end else if (eret) begin
                exl <= 1'b0;
            end else if (wr && cp0_waddr == CP0_STATUS) begin
                im  <= cp0_wdata[15:8];
                exl <= cp0_wdata[1];
                ie  <= cp0_wdata[0];
            end
            if (wr && cp0_waddr == CP0_EPC)
                epc <= cp0_wdata;
        end
    end
endmodule
